// File: rtl/enigma_exec_tracker.sv
// enigma_exec_tracker: consumes buffer port C, models QoS-dependent
// execution latency in a slot table, emits completions on port D.
module enigma_exec_tracker #(
    parameter int NSLOT    = 4,
    parameter int BASE_LAT = 4,
    parameter int CNT_W    = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_c,
    output logic         ready_c,
    input  logic [127:0] payload_c,
    input  logic [5:0]   id_c,
    input  logic [1:0]   qos_c,
    output logic         conflict_c,
    output logic         release_c,
    output logic [5:0]   releaseid_c,
    output logic         valid_d,
    input  logic         ready_d,
    output logic [127:0] payload_d,
    output logic [5:0]   id_d
);

    localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [63:0]      busy;
    logic [NSLOT-1:0] slot_vld;
    logic [5:0]       slot_id  [NSLOT];
    logic [127:0]     slot_pl  [NSLOT];
    logic [CNT_W-1:0] slot_cnt [NSLOT];

    logic [NSLOT-1:0] slot_done;
    logic             free_any;
    logic             done_any;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    done_idx;
    logic             accept;
    logic             drain;
    logic             load;
    logic [CNT_W-1:0] cnt_init;

    // Lowest-index free slot and lowest-index finished slot.
    always_comb begin
        free_idx = '0;
        done_idx = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_done[i] = slot_vld[i] && (slot_cnt[i] == '0);
        end
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!slot_vld[i]) free_idx = IW'(i);
            if (slot_done[i]) done_idx = IW'(i);
        end
    end

    assign free_any   = ~&slot_vld;
    assign done_any   = |slot_done;
    assign conflict_c = rst_n & valid_c & busy[id_c];
    assign ready_c    = rst_n & free_any & ~conflict_c;
    assign accept     = valid_c & ready_c;
    assign drain      = valid_d & ready_d;
    assign load       = (~valid_d | drain) & done_any;
    // qos 3 is fastest; each step down adds four cycles.
    assign cnt_init   = CNT_W'(BASE_LAT) + CNT_W'({~qos_c, 2'b00});

    // Slot table: countdown, retire into output register, accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (slot_vld[i] && slot_cnt[i] != '0)
                    slot_cnt[i] <= slot_cnt[i] - 1'b1;
            end
            if (load)
                slot_vld[done_idx] <= 1'b0;
            if (accept) begin
                slot_vld[free_idx] <= 1'b1;
                slot_id[free_idx]  <= id_c;
                slot_pl[free_idx]  <= payload_c;
                slot_cnt[free_idx] <= cnt_init;
            end
        end
    end

    // Output register on port D; holds while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_d   <= 1'b0;
            id_d      <= '0;
            payload_d <= '0;
        end else if (load) begin
            valid_d   <= 1'b1;
            id_d      <= slot_id[done_idx];
            payload_d <= slot_pl[done_idx];
        end else if (drain) begin
            valid_d   <= 1'b0;
        end
    end

    // One-cycle release pulse back to the buffer after each handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            release_c   <= 1'b0;
            releaseid_c <= '0;
        end else begin
            release_c   <= drain;
            releaseid_c <= drain ? id_d : 6'd0;
        end
    end

    // Busy map: set on accept, cleared on completion handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (drain)
                busy[id_d] <= 1'b0;
            if (accept)
                busy[id_c] <= 1'b1;
        end
    end

endmodule
